// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ write requesters share the single
// write port of a synchronous FIFO. A granted requester may write up to
// BURST_MAX words before the grant is re-arbitrated. When the grant ends and
// another requester is waiting, the new grant is loaded on the same edge, so
// the arbiter never drops back to IDLE between grants.
//
// Ports
//   clk_i         in   1                   clock, rising edge
//   rst_i         in   1                   asynchronous reset, active low
//   req_i         in   NUM_REQ             bit n: requester n holds a word
//   wdata_i       in   NUM_REQ*DATA_WIDTH  word n at [n*DATA_WIDTH +: DATA_WIDTH]
//   ack_o         out  NUM_REQ             bit n: word of requester n written
//   grant_o       out  NUM_REQ             registered one-hot grant, 0 when idle
//   fifo_full_i   in   1                   FIFO full flag
//   fifo_wr_en_o  out  1                   FIFO write enable
//   fifo_wdata_o  out  DATA_WIDTH          FIFO write data (0 when not writing)
//   busy_o        out  1                   high while a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 10,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic [NUM_REQ-1:0]              grant_o,
  input  logic                            fifo_full_i,
  output logic                            fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]           fifo_wdata_o,
  output logic                            busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      g_q, g_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;

  logic                  busy;
  logic                  req_g;
  logic                  wr;
  logic                  burst_end;
  logic                  term;
  logic [DATA_WIDTH-1:0] wdata_g;

  // First requesting index searching upward from (last+1) with wrap-around.
  // The loop runs from the farthest offset down to the nearest so that the
  // nearest hit is the one that survives. If last itself is the only
  // requester it is found at offset NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (req[idx]) begin
        pick = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  // Select request bit and data word of the granted requester.
  always_comb begin
    req_g   = 1'b0;
    wdata_g = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (g_q == IDX_W'(n)) begin
        req_g   = req_i[n];
        wdata_g = wdata_i[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy      = (state_q == S_GRANT);
  assign wr        = busy & req_g & ~fifo_full_i;
  assign burst_end = wr & (cnt_q == CNT_W'(BURST_MAX - 1));
  // A grant ends when its owner withdraws (even if the FIFO is full at the
  // same time) or when the last word of a full burst is written.
  assign term      = busy & (~req_g | burst_end);

  assign busy_o       = busy;
  assign grant_o      = grant_q;
  assign fifo_wr_en_o = wr;
  assign fifo_wdata_o = wr ? wdata_g : '0;
  assign ack_o        = NUM_REQ'(wr) << g_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          g_d     = rr_pick(req_i, last_q);
          grant_d = NUM_REQ'(1) << g_d;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      default: begin
        if (term) begin
          last_d = g_q;
          // The finishing requester is still eligible here: after a full
          // burst with its request still high and nobody else waiting it
          // wins the search again and is re-granted at once.
          if (|req_i) begin
            g_d     = rr_pick(req_i, g_q);
            grant_d = NUM_REQ'(1) << g_d;
            cnt_d   = '0;
            state_d = S_GRANT;
          end else begin
            grant_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else if (wr) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      // Pointer at the top index so requester 0 wins first after reset.
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. Requesters are modelled as word lists
// that advance one word the cycle after an ack. A 16-deep FIFO model sits on
// the write port and drives fifo_full_i. Expected writes (requester, word,
// cycle offset) are queued by each test; a negedge monitor pops and compares
// every write the DUT performs, and compares FIFO read-back against the
// sequence of acked words.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR     = 4;
  localparam int DW     = 10;
  localparam int BM     = 4;
  localparam int FDEPTH = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR-1:0]     ack_o;
  logic [NR-1:0]     grant_o;
  logic              fifo_full_i;
  logic              fifo_wr_en_o;
  logic [DW-1:0]     fifo_wdata_o;
  logic              busy_o;

  always #5 clk_i = ~clk_i;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .BURST_MAX (BM)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .grant_o     (grant_o),
    .fifo_full_i (fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wdata_o(fifo_wdata_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    int          req;
    logic [DW-1:0] data;
    int          cyc;   // expected cycle offset, -1 = any
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] mfifo[$];
  logic [DW-1:0] ackq[$];

  logic [DW-1:0] words[NR][8];
  int            head[NR];
  int            len[NR];

  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  int            tbase = 0;
  int            fs    = -1;
  int            fe    = -2;
  int            peak  = 0;
  bit            rd_en = 1'b1;
  logic [NR-1:0] ack_s = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] wd(input int t, input int n, input int k);
    logic [3:0] tt;
    logic [1:0] nn;
    logic [3:0] kk;
    tt = t[3:0];
    nn = n[1:0];
    kk = k[3:0];
    return {tt, nn, kk};
  endfunction

  task automatic load(input int n, input int cnt, input int t);
    for (int k = 0; k < cnt; k++) words[n][k] = wd(t, n, k);
    len[n]  = cnt;
    head[n] = 0;
  endtask

  task automatic expect_wr(input int n, input int k, input int t, input int c);
    exp_t e;
    e.req  = n;
    e.data = wd(t, n, k);
    e.cyc  = c;
    expq.push_back(e);
  endtask

  task automatic drive();
    for (int n = 0; n < NR; n++) begin
      req_i[n]             = (head[n] < len[n]);
      wdata_i[n*DW +: DW]  = (head[n] < len[n]) ? words[n][head[n]] : '0;
    end
    fifo_full_i = ((cyc - tbase) >= fs && (cyc - tbase) <= fe) || (mfifo.size() >= FDEPTH);
  endtask

  // Advance one cycle: requesters that were acked present their next word.
  task automatic step();
    @(posedge clk_i);
    #1;
    for (int n = 0; n < NR; n++) begin
      if (ack_s[n] && head[n] < len[n]) head[n]++;
    end
    drive();
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int n = 0; n < NR; n++) begin
      len[n]  = 0;
      head[n] = 0;
    end
    fs = -1;
    fe = -2;
    drive();
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_en", fifo_wr_en_o, 0);
    step();
    step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic wait_done(input int budget);
    int i;
    bit pend;
    i = 0;
    pend = 1'b1;
    while (pend && i < budget) begin
      step();
      i++;
      pend = (expq.size() > 0) || busy_o;
      for (int n = 0; n < NR; n++) if (head[n] < len[n]) pend = 1'b1;
    end
    check("done_in_budget", pend, 0);
    expq.delete();
    step();
    check("idle_grant", grant_o, 0);
    check("idle_busy", busy_o, 0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t          e;
    logic [DW-1:0] rb;
    forever begin
      @(negedge clk_i);
      check("ack_onehot", ($countones(ack_o) <= 1), 1);
      if (fifo_wr_en_o) begin
        check("wr_while_full", fifo_full_i, 0);
        check("fifo_no_overflow", (mfifo.size() < FDEPTH), 1);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got data %0h ack %0h expected no write (cycle %0d)",
                   fifo_wdata_o, ack_o, cyc);
        end else begin
          e = expq.pop_front();
          check("ack_req", ack_o, 64'(1) << e.req);
          check("wdata", fifo_wdata_o, e.data);
          if (e.cyc >= 0) check("write_cycle", cyc - tbase, e.cyc);
        end
        for (int n = 0; n < NR; n++) begin
          if (ack_o[n] && head[n] < len[n]) ackq.push_back(words[n][head[n]]);
        end
        mfifo.push_back(fifo_wdata_o);
        if (mfifo.size() > peak) peak = mfifo.size();
      end else begin
        check("ack_idle", ack_o, 0);
        check("wdata_idle", fifo_wdata_o, 0);
      end
      if (rd_en && mfifo.size() > 0) begin
        rb = mfifo.pop_front();
        if (ackq.size() > 0) check("readback", rb, ackq.pop_front());
        else check("readback_extra", 1, 0);
      end
      ack_s = ack_o;
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b0;
    req_i       = '0;
    wdata_i     = '0;
    fifo_full_i = 1'b0;
    for (int n = 0; n < NR; n++) begin
      len[n]  = 0;
      head[n] = 0;
    end

    // Single requester, 6 words: burst of 4, immediate re-grant, 2 more.
    do_reset();
    load(0, 6, 1);
    for (int k = 0; k < 6; k++) expect_wr(0, k, 1, k + 1);
    step();
    tbase = cyc;
    step();
    check("t1_grant", grant_o, 4'b0001);
    wait_done(40);

    // Four requesters, 2 words each: order 0,1,2,3 without IDLE gaps.
    do_reset();
    for (int n = 0; n < NR; n++) load(n, 2, 2);
    for (int n = 0; n < NR; n++)
      for (int k = 0; k < 2; k++) expect_wr(n, k, 2, 1 + 3*n + k);
    step();
    tbase = cyc;
    wait_done(40);

    // Requester 2, FIFO full for 3 cycles mid-burst.
    do_reset();
    load(2, 4, 3);
    expect_wr(2, 0, 3, 1);
    expect_wr(2, 1, 3, 2);
    expect_wr(2, 2, 3, 6);
    expect_wr(2, 3, 3, 7);
    step();
    tbase = cyc;
    fs = 3;
    fe = 5;
    repeat (4) step();
    check("t3_grant_held", grant_o, 4'b0100);
    check("t3_busy_held", busy_o, 1);
    wait_done(40);
    fs = -1;
    fe = -2;

    // Two requesters, 5 words each: 0(4),1(4),0(1),1(1).
    do_reset();
    load(0, 5, 4);
    load(1, 5, 4);
    for (int k = 0; k < 4; k++) expect_wr(0, k, 4, k + 1);
    for (int k = 0; k < 4; k++) expect_wr(1, k, 4, k + 5);
    expect_wr(0, 4, 4, 9);
    expect_wr(1, 4, 4, 11);
    step();
    tbase = cyc;
    wait_done(60);

    // Reset mid-burst after 2 writes, then requester 3 gets the first grant.
    do_reset();
    load(1, 5, 5);
    expect_wr(1, 0, 5, 1);
    expect_wr(1, 1, 5, 2);
    step();
    tbase = cyc;
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    check("t5_rst_ack", ack_o, 0);
    check("t5_rst_wr_en", fifo_wr_en_o, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_grant", grant_o, 0);
    check("t5_rst_wdata", fifo_wdata_o, 0);
    check("t5_acked_before_rst", expq.size(), 0);
    len[1] = 0;
    step();
    step();
    load(3, 2, 5);
    expect_wr(3, 0, 5, 1);
    expect_wr(3, 1, 5, 2);
    step();
    rst_i = 1'b1;
    tbase = cyc;
    step();
    check("t5_first_grant", grant_o, 4'b1000);
    wait_done(40);

    // 20 words into a 16-deep FIFO with reads held off at first.
    do_reset();
    rd_en = 1'b0;
    peak  = mfifo.size();
    for (int n = 0; n < NR; n++) load(n, 5, 6);
    for (int n = 0; n < NR; n++)
      for (int k = 0; k < 4; k++) expect_wr(n, k, 6, -1);
    for (int n = 0; n < NR; n++) expect_wr(n, 4, 6, -1);
    step();
    tbase = cyc;
    repeat (40) step();
    check("t6_pending_while_full", expq.size(), 4);
    check("t6_fifo_level", mfifo.size(), FDEPTH);
    check("t6_grant_held", grant_o, 4'b0001);
    rd_en = 1'b1;
    wait_done(100);
    begin
      int i;
      i = 0;
      while (mfifo.size() > 0 && i < 40) begin
        step();
        i++;
      end
    end
    check("t6_fifo_drained", mfifo.size(), 0);
    check("t6_all_acked_read", ackq.size(), 0);
    check("t6_peak_level", peak, FDEPTH);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters sharing one synch_fifo write port.
REQ-002 Parameter DATA_WIDTH, default 10: word width, equal to the FIFO DATA_WIDTH.
REQ-003 Parameter BURST_MAX, default 4: maximum words accepted per grant before re-arbitration.
REQ-004 Port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 Port rst_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port req_i, input, NUM_REQ bits: bit n high = requester n holds a valid word.
REQ-007 Port wdata_i, input, NUM_REQ*DATA_WIDTH bits: requester n word at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port ack_o, output, NUM_REQ bits: bit n high = requester n word written this cycle.
REQ-009 Port grant_o, output, NUM_REQ bits: one-hot registered grant, all-zero when idle.
REQ-010 Port fifo_full_i, input, 1 bit: full_o of the downstream FIFO.
REQ-011 Port fifo_wr_en_o, output, 1 bit: drives FIFO wr_en_i.
REQ-012 Port fifo_wdata_o, output, DATA_WIDTH bits: drives FIFO wdata_i.
REQ-013 Port busy_o, output, 1 bit: high while in GRANT state.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 Registered state: state, grant index g, last-served pointer last, burst counter cnt (width clog2(BURST_MAX+1)).
REQ-016 Arbitration SHALL be round-robin: the candidate is the first n with req_i[n]=1, searching (last+1) mod NUM_REQ upward with wrap.
REQ-017 IDLE with any req_i bit high: at the next edge load g = candidate, set grant_o one-hot at g, cnt=0, move to GRANT; no write occurs in the IDLE cycle.
REQ-018 In GRANT, write condition W = req_i[g] & ~fifo_full_i.
REQ-019 fifo_wr_en_o = W, fifo_wdata_o = wdata_i slice g, ack_o = W one-hot at g; all combinational from registered g; fifo_wdata_o = 0 when W=0.
REQ-020 Each W cycle increments cnt; the requester SHALL present its next word in the cycle after ack.
REQ-021 A grant terminates in the cycle where req_i[g]=0, or where W=1 and cnt=BURST_MAX-1.
REQ-022 On termination: last=g; if another requester is pending, re-arbitrate in the same cycle (last=g for the search), load the new grant, cnt=0, and stay in GRANT (zero-bubble hand-off); otherwise go to IDLE with grant_o=0.
REQ-023 A requester whose burst ends by BURST_MAX with req still high and no other requester pending SHALL be re-granted immediately.
REQ-024 fifo_full_i high: no write, no ack, cnt holds, grant held indefinitely; no timeout.
REQ-025 fifo_full_i and req_i[g] drop together: termination per REQ-021, no write.
REQ-026 At most one ack_o bit SHALL be high per cycle; fifo_wr_en_o SHALL never be high while fifo_full_i is high.
REQ-027 Changes on non-granted req_i bits SHALL not affect the current grant.

Reset
REQ-028 rst_i low SHALL immediately force state=IDLE, grant_o=0, cnt=0, last=NUM_REQ-1, so requester 0 has first priority after reset.
REQ-029 During reset, and because of it, ack_o, fifo_wr_en_o and busy_o SHALL be 0; fifo_wdata_o SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further write; words already acked remain in the FIFO.

Verification
REQ-031 Single requester: req_i=0001 held for 6 words, FIFO not full -> grant at cycle 1, writes in cycles 1-4, re-grant to requester 0, writes in cycles 5-6, acks match data order.
REQ-032 All four requesting, 2 words each -> grant order 0,1,2,3, eight writes with no idle cycle between grants.
REQ-033 Requester 2 granted; fifo_full_i high for 3 cycles mid-burst -> fifo_wr_en_o=0 and ack_o=0 for those cycles, grant and cnt unchanged, burst resumes and totals 4 words.
REQ-034 req_i=0011 continuous, 5 words each, BURST_MAX=4 -> grants 0(4),1(4),0(1),1(1).
REQ-035 rst_i pulled low during a burst after 2 writes -> outputs 0 the same cycle; after release with req_i=1000 -> first grant goes to requester 3.
REQ-036 Bench with a synch_fifo of DEPTH 16 and 20 words offered -> the FIFO never overflows and the read-back sequence equals the acked sequence.
